fifo_write_arbiter: RTL
=======================

# fifo_write_arbiter

Round-robin arbiter that shares the single write port of the team's synchronous FIFO (`fifo`) between NREQ producers. Each producer presents data with a valid/ready handshake. The arbiter grants one producer at a time, drives the FIFO `we`/`datain` pair, and stalls on the FIFO `full` flag. It sits directly in front of `fifo`, so no producer ever drives the FIFO write port itself.

## Interface
- WIDTH, 8, data word width; must match the FIFO width.
- NREQ, 4, number of requesters; legal range 2..8.
- BURST, 4, maximum words per grant when bursting is compiled in; legal range 1..16.

- clk  in  1  rising-edge clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  bit i: requester i has a word on its data slice.
- req_data  in  NREQ*WIDTH  slice i = req_data[i*WIDTH +: WIDTH].
- req_ready  out  NREQ  bit i: word i is accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_we  out  1  FIFO write enable.
- fifo_datain  out  WIDTH  FIFO write data.
- grant  out  NREQ  one-hot current owner; zero when idle.
- busy  out  1  high while in GRANT.

## Operation
- Two-state FSM: IDLE, GRANT. Registers: state, owner index, last_owner, burst counter (clog2(BURST+1) bits).
- **IDLE**
  - If any req_valid is high, pick the first valid requester searching from last_owner+1 upward, modulo NREQ.
  - Register the winner as owner and go to GRANT. Arbitration costs exactly one cycle; no transfer happens in IDLE.
- **GRANT**
  - A transfer occurs when req_valid[owner] & ~fifo_full.
  - On a transfer: fifo_we=1, fifo_datain=req_data[owner], req_ready[owner]=1, and the burst counter increments.
- **Release GRANT → IDLE** on the first of these conditions; last_owner←owner on release:
  - req_valid[owner] is low (owner idle or has withdrawn).
  - A transfer brings the burst counter to BURST (bursting compiled in) or completes one word (bursting compiled out).
- **Combinational outputs** (fifo_we, fifo_datain, req_ready) depend on the registered state plus req_valid and fifo_full. fifo_datain=0 whenever fifo_we=0.
- **Requester rule:** once req_valid is raised, req_data must stay stable until req_ready is seen. Non-owners always see req_ready=0.
- **Full:** while fifo_full=1 in GRANT there is no transfer, the burst counter holds, and the grant is held indefinitely (no timeout). Transfers resume on the first cycle fifo_full=0.

## Timing
- **Reset values:** state=IDLE, grant=0, busy=0, fifo_we=0, fifo_datain=0, req_ready=0, burst counter=0, last_owner=NREQ-1, so requester 0 has priority after reset.
- **Latency:** req_valid rises in cycle N with the arbiter idle → grant and busy high in N+1 → first write in N+1 if not full.
- **Throughput** with continuous requesters: BURST words per BURST+1 cycles, because of the idle arbitration bubble.
- **Simultaneous events:**
  - The final burst transfer and the owner dropping valid in the same cycle cause a single release.
  - fifo_full high on what would be the final transfer cycle means no transfer and no release.
- **Reset mid-burst:** takes effect at the next edge. All outputs return to reset values, the partial burst is abandoned, and no write occurs in the reset cycle.

## Configuration
- `FIFO_ARB_BURST_EN`
  - Defined: the grant is held for up to BURST consecutive accepted words.
  - Undefined: the grant is released after every accepted word (strict per-word round robin), BURST is ignored, and the burst counter is not synthesised.

## Test plan
Bench settings: WIDTH=8, NREQ=4, BURST=4, with a behavioural FIFO model of depth 16. Scenarios run with the macro defined unless stated.

1. **Reset:** pulse reset with all inputs active → one cycle later grant=0000, busy=0, fifo_we=0, req_ready=0000.
2. **Single requester:** requester 1 presents words 0x11..0x16 with fifo_full=0 → grant=0010 one cycle later. Expect 4 writes, 1 idle cycle, then 2 writes. The FIFO holds 0x11..0x16 in order.
3. **All four valid continuously:** → grant order 0,1,2,3,0 with 4 words each. With the macro undefined → 1 word each, in the same order.
4. **FIFO full mid-burst:** fifo_full=1 for 3 cycles after the second word of a burst → fifo_we=0 and req_ready=0 for 3 cycles, grant held. The remaining 2 words follow, with no word lost or duplicated.
5. **Owner withdraws:** the owner drops valid after 2 words while requester 3 is waiting → release, then grant=1000 after one idle cycle.
6. **Reset during a burst:** reset during requester 2's burst → outputs are at reset values next cycle. With requesters 0 and 2 both valid afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the single FIFO write port between NREQ valid/ready producers.
// Define FIFO_ARB_BURST_EN to hold a grant for up to BURST words; undefined gives one word per grant.
module fifo_write_arbiter #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned BURST = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  fifo_full,
   output logic                  fifo_we,
   output logic [WIDTH-1:0]      fifo_datain,
   output logic [NREQ-1:0]       grant,
   output logic                  busy
);

   localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef FIFO_ARB_BURST_EN
   localparam int unsigned CNTW = $clog2(BURST + 1);
`endif

   if (NREQ < 2 || NREQ > 8) begin : gen_bad_nreq
      $error("fifo_write_arbiter: NREQ must be in 2..8");
   end
   if (BURST < 1 || BURST > 16) begin : gen_bad_burst
      $error("fifo_write_arbiter: BURST must be in 1..16");
   end

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e            state_q;
   logic [IDXW-1:0]   owner_q;
   logic [IDXW-1:0]   last_owner_q;
`ifdef FIFO_ARB_BURST_EN
   logic [CNTW-1:0]   burst_cnt_q;
`endif

   logic              pick_found;
   logic [IDXW-1:0]   pick_idx;
   logic [IDXW-1:0]   cand_idx;
   int unsigned       cand;
   logic              owner_valid;
   logic              xfer;
   logic              last_beat;
   logic              release_grant;

   // First valid requester strictly after last_owner, wrapping modulo NREQ.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = 32'(last_owner_q) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = IDXW'(cand);
         if (!pick_found && req_valid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   assign owner_valid = req_valid[owner_q];

   // Gating with reset keeps the reset cycle from writing a stale burst word.
   assign xfer = ~reset & (state_q == StGrant) & owner_valid & ~fifo_full;

`ifdef FIFO_ARB_BURST_EN
   assign last_beat = (burst_cnt_q == CNTW'(BURST - 1));
`else
   assign last_beat = 1'b1;
`endif

   assign release_grant = (state_q == StGrant) & (~owner_valid | (xfer & last_beat));

   always_comb begin
      fifo_we     = xfer;
      fifo_datain = '0;
      req_ready   = '0;
      if (xfer) begin
         fifo_datain        = req_data[32'(owner_q) * WIDTH +: WIDTH];
         req_ready[owner_q] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         owner_q      <= '0;
         last_owner_q <= IDXW'(NREQ - 1);
         grant        <= '0;
         busy         <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
         burst_cnt_q  <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pick_found) begin
                  state_q         <= StGrant;
                  owner_q         <= pick_idx;
                  grant           <= '0;
                  grant[pick_idx] <= 1'b1;
                  busy            <= 1'b1;
`ifdef FIFO_ARB_BURST_EN
                  burst_cnt_q     <= '0;
`endif
               end
            end
            StGrant: begin
               if (release_grant) begin
                  state_q      <= StIdle;
                  last_owner_q <= owner_q;
                  grant        <= '0;
                  busy         <= 1'b0;
`ifdef FIFO_ARB_BURST_EN
                  burst_cnt_q  <= '0;
`endif
               end
`ifdef FIFO_ARB_BURST_EN
               else if (xfer) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
   a_no_write_full: assert property (@(posedge clk) disable iff (reset) fifo_full |-> !fifo_we);

endmodule
